// File: rtl/apb_node_pkg.sv
// Shared types and constants for the APB node with slave timeout.
package apb_node_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } node_state_e;

  // Read data returned upstream for decode misses and timed-out transfers
  localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// First-match address decoder: the lowest-index window containing addr wins.
module apb_addr_decoder
  import apb_node_pkg::*;
#(
  parameter int NB_SLAVES  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = idx_width(NB_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] start_addr,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] end_addr,
  output logic                            hit,
  output logic [IDX_W-1:0]                idx
);

  // Scan from the top down so a lower matching index overwrites a higher one
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NB_SLAVES - 1; i >= 0; i--) begin
      if ((addr >= start_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (addr <= end_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_node_timeout.sv
// APB fan-out node: decodes upstream requests onto one of NB_SLAVES ports and
// aborts with an error response if the selected slave stalls too long.
module apb_node_timeout
  import apb_node_pkg::*;
#(
  parameter int NB_SLAVES      = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ADDR_WIDTH-1:0]           slave_PADDR,
  input  logic [DATA_WIDTH-1:0]           slave_PWDATA,
  input  logic                            slave_PWRITE,
  input  logic                            slave_PSEL,
  input  logic                            slave_PENABLE,
  output logic [DATA_WIDTH-1:0]           slave_PRDATA,
  output logic                            slave_PREADY,
  output logic                            slave_PSLVERR,
  output logic [ADDR_WIDTH-1:0]           master_PADDR,
  output logic [DATA_WIDTH-1:0]           master_PWDATA,
  output logic                            master_PWRITE,
  output logic [NB_SLAVES-1:0]            master_PSEL,
  output logic                            master_PENABLE,
  input  logic [NB_SLAVES*DATA_WIDTH-1:0] master_PRDATA,
  input  logic [NB_SLAVES-1:0]            master_PREADY,
  input  logic [NB_SLAVES-1:0]            master_PSLVERR,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] END_ADDR_i
);

  localparam int IDX_W = idx_width(NB_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  node_state_e           state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_hit;
  logic [NB_SLAVES-1:0]  psel_q;
  logic                  penable_q;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout;
  logic                  unused_penable;

  // Upstream requests are accepted with PSEL alone, so PENABLE carries no information
  assign unused_penable = slave_PENABLE;

  apb_addr_decoder #(
    .NB_SLAVES  (NB_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_addr_decoder (
    .addr       (slave_PADDR),
    .start_addr (START_ADDR_i),
    .end_addr   (END_ADDR_i),
    .hit        (dec_hit),
    .idx        (dec_idx)
  );

  assign master_PADDR   = slave_PADDR;
  assign master_PWDATA  = slave_PWDATA;
  assign master_PWRITE  = slave_PWRITE;
  assign master_PSEL    = psel_q;
  assign master_PENABLE = penable_q;

  assign sel_ready = master_PREADY[idx_q];
  assign sel_err   = master_PSLVERR[idx_q];
  assign sel_rdata = master_PRDATA[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  // A slave answering in the last allowed cycle still wins over the timeout
  assign timeout   = (state == ACCESS) && !sel_ready && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          psel_q    <= '0;
          penable_q <= 1'b0;
          if (slave_PSEL) begin
            if (dec_hit) begin
              idx_q  <= dec_idx;
              cnt    <= '0;
              psel_q <= NB_SLAVES'(1) << dec_idx;
              state  <= SETUP;
            end else begin
              state <= ERROR;
            end
          end
        end
        SETUP: begin
          if (!slave_PSEL) begin
            psel_q <= '0;
            state  <= IDLE;
          end else begin
            penable_q <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!slave_PSEL || sel_ready || timeout) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            state     <= IDLE;
          end else if (cnt < CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        ERROR: begin
          psel_q    <= '0;
          penable_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Upstream response is only ever non-zero in a completing ACCESS or ERROR cycle
  always_comb begin
    slave_PREADY  = 1'b0;
    slave_PSLVERR = 1'b0;
    slave_PRDATA  = '0;
    case (state)
      ACCESS: begin
        if (slave_PSEL) begin
          if (sel_ready) begin
            slave_PREADY  = 1'b1;
            slave_PSLVERR = sel_err;
            slave_PRDATA  = sel_rdata;
          end else if (timeout) begin
            slave_PREADY  = 1'b1;
            slave_PSLVERR = 1'b1;
            slave_PRDATA  = DATA_WIDTH'(ERR_RDATA);
          end
        end
      end
      ERROR: begin
        slave_PREADY  = 1'b1;
        slave_PSLVERR = 1'b1;
        slave_PRDATA  = DATA_WIDTH'(ERR_RDATA);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_node_timeout.sv
// Directed bench for apb_node_timeout with TIMEOUT_CYCLES = 4.
module tb_apb_node_timeout;

  localparam int NB = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] ERR = 32'hBADACCE5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     slave_PADDR;
  logic [DW-1:0]     slave_PWDATA;
  logic              slave_PWRITE;
  logic              slave_PSEL;
  logic              slave_PENABLE;
  logic [DW-1:0]     slave_PRDATA;
  logic              slave_PREADY;
  logic              slave_PSLVERR;
  logic [AW-1:0]     master_PADDR;
  logic [DW-1:0]     master_PWDATA;
  logic              master_PWRITE;
  logic [NB-1:0]     master_PSEL;
  logic              master_PENABLE;
  logic [NB*DW-1:0]  master_PRDATA;
  logic [NB-1:0]     master_PREADY;
  logic [NB-1:0]     master_PSLVERR;
  logic [NB*AW-1:0]  start_addr;
  logic [NB*AW-1:0]  end_addr;

  int checks = 0;
  int fails  = 0;

  apb_node_timeout #(
    .NB_SLAVES      (NB),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .slave_PADDR    (slave_PADDR),
    .slave_PWDATA   (slave_PWDATA),
    .slave_PWRITE   (slave_PWRITE),
    .slave_PSEL     (slave_PSEL),
    .slave_PENABLE  (slave_PENABLE),
    .slave_PRDATA   (slave_PRDATA),
    .slave_PREADY   (slave_PREADY),
    .slave_PSLVERR  (slave_PSLVERR),
    .master_PADDR   (master_PADDR),
    .master_PWDATA  (master_PWDATA),
    .master_PWRITE  (master_PWRITE),
    .master_PSEL    (master_PSEL),
    .master_PENABLE (master_PENABLE),
    .master_PRDATA  (master_PRDATA),
    .master_PREADY  (master_PREADY),
    .master_PSLVERR (master_PSLVERR),
    .START_ADDR_i   (start_addr),
    .END_ADDR_i     (end_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [31:0] a, input logic w, input logic [31:0] d);
    slave_PADDR   = a;
    slave_PWRITE  = w;
    slave_PWDATA  = d;
    slave_PSEL    = 1'b1;
    slave_PENABLE = 1'b1;
  endtask

  task automatic release_req();
    slave_PSEL    = 1'b0;
    slave_PENABLE = 1'b0;
  endtask

  task automatic set_slave(input int i, input logic rdy, input logic err, input logic [31:0] d);
    master_PREADY[i]         = rdy;
    master_PSLVERR[i]        = err;
    master_PRDATA[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_req(32'h1A10_0004, 1'b0, 32'h0);
    repeat (2) tick();
    sample();
    checks++; if (master_PSEL !== 8'h00) begin fails++; $display("[TB] FAIL reset_psel: got %b expected %b", master_PSEL, 8'h00); end
    checks++; if (master_PENABLE !== 1'b0) begin fails++; $display("[TB] FAIL reset_penable: got %b expected 0", master_PENABLE); end
    checks++; if ({slave_PREADY, slave_PSLVERR} !== 2'b00) begin fails++; $display("[TB] FAIL reset_resp: got %b expected 00", {slave_PREADY, slave_PSLVERR}); end
    checks++; if (slave_PRDATA !== 32'h0) begin fails++; $display("[TB] FAIL reset_prdata: got %h expected 0", slave_PRDATA); end
    release_req();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    tick();
    set_slave(2, 1'b0, 1'b0, 32'h1234_5678);
    drive_req(32'h1A10_0004, 1'b0, 32'h0);
    sample();
    checks++; if (master_PSEL !== 8'h00) begin fails++; $display("[TB] FAIL read_idle_psel: got %b expected %b", master_PSEL, 8'h00); end
    checks++; if (slave_PREADY !== 1'b0) begin fails++; $display("[TB] FAIL read_idle_pready: got %b expected 0", slave_PREADY); end
    tick(); sample();
    checks++; if (master_PSEL !== 8'b0000_0100) begin fails++; $display("[TB] FAIL read_setup_psel: got %b expected %b", master_PSEL, 8'b0000_0100); end
    checks++; if (master_PENABLE !== 1'b0) begin fails++; $display("[TB] FAIL read_setup_penable: got %b expected 0", master_PENABLE); end
    checks++; if (master_PADDR !== 32'h1A10_0004 || master_PWRITE !== 1'b0) begin fails++; $display("[TB] FAIL read_passthru: got %h/%b expected 1a100004/0", master_PADDR, master_PWRITE); end
    tick(); sample();
    checks++; if (master_PENABLE !== 1'b1) begin fails++; $display("[TB] FAIL read_access_penable: got %b expected 1", master_PENABLE); end
    checks++; if (slave_PREADY !== 1'b0 || slave_PRDATA !== 32'h0) begin fails++; $display("[TB] FAIL read_wait1: got %b/%h expected 0/0", slave_PREADY, slave_PRDATA); end
    tick(); sample();
    checks++; if (slave_PREADY !== 1'b0) begin fails++; $display("[TB] FAIL read_wait2: got %b expected 0", slave_PREADY); end
    tick();
    set_slave(2, 1'b1, 1'b0, 32'h1234_5678);
    sample();
    checks++; if (slave_PREADY !== 1'b1 || slave_PSLVERR !== 1'b0) begin fails++; $display("[TB] FAIL read_resp: got %b/%b expected 1/0", slave_PREADY, slave_PSLVERR); end
    checks++; if (slave_PRDATA !== 32'h1234_5678) begin fails++; $display("[TB] FAIL read_data: got %h expected 12345678", slave_PRDATA); end
    tick();
    release_req();
    set_slave(2, 1'b0, 1'b0, 32'hDEAD_0002);
    sample();
    checks++; if (master_PSEL !== 8'h00 || slave_PREADY !== 1'b0) begin fails++; $display("[TB] FAIL read_after: got %b/%b expected 00000000/0", master_PSEL, slave_PREADY); end
  endtask

  task automatic test_unmapped();
    tick();
    drive_req(32'hFFFF_0000, 1'b0, 32'h0);
    sample();
    checks++; if (slave_PREADY !== 1'b0) begin fails++; $display("[TB] FAIL unmapped_c1: got %b expected 0", slave_PREADY); end
    tick(); sample();
    checks++; if (slave_PREADY !== 1'b1 || slave_PSLVERR !== 1'b1) begin fails++; $display("[TB] FAIL unmapped_resp: got %b/%b expected 1/1", slave_PREADY, slave_PSLVERR); end
    checks++; if (slave_PRDATA !== ERR) begin fails++; $display("[TB] FAIL unmapped_data: got %h expected %h", slave_PRDATA, ERR); end
    checks++; if (master_PSEL !== 8'h00) begin fails++; $display("[TB] FAIL unmapped_psel: got %b expected 00000000", master_PSEL); end
    tick();
    release_req();
    sample();
    checks++; if (slave_PREADY !== 1'b0 || slave_PSLVERR !== 1'b0 || slave_PRDATA !== 32'h0) begin fails++; $display("[TB] FAIL unmapped_after: got %b/%b/%h expected 0/0/0", slave_PREADY, slave_PSLVERR, slave_PRDATA); end
  endtask

  task automatic test_timeout();
    set_slave(2, 1'b0, 1'b0, 32'h7777_0002);
    tick();
    drive_req(32'h1A10_0010, 1'b0, 32'h0);
    tick(); tick();
    for (int k = 1; k <= 3; k++) begin
      sample();
      checks++; if (slave_PREADY !== 1'b0) begin fails++; $display("[TB] FAIL timeout_wait%0d: got %b expected 0", k, slave_PREADY); end
      tick();
    end
    sample();
    checks++; if (slave_PREADY !== 1'b1 || slave_PSLVERR !== 1'b1) begin fails++; $display("[TB] FAIL timeout_resp: got %b/%b expected 1/1", slave_PREADY, slave_PSLVERR); end
    checks++; if (slave_PRDATA !== ERR) begin fails++; $display("[TB] FAIL timeout_data: got %h expected %h", slave_PRDATA, ERR); end
    checks++; if (master_PSEL !== 8'b0000_0100) begin fails++; $display("[TB] FAIL timeout_psel_held: got %b expected 00000100", master_PSEL); end
    tick();
    release_req();
    sample();
    checks++; if (master_PSEL !== 8'h00 || master_PENABLE !== 1'b0) begin fails++; $display("[TB] FAIL timeout_release: got %b/%b expected 00000000/0", master_PSEL, master_PENABLE); end
    set_slave(2, 1'b0, 1'b0, 32'hDEAD_0002);
  endtask

  task automatic test_ready_at_timeout();
    set_slave(0, 1'b0, 1'b0, 32'h5A5A_0001);
    tick();
    drive_req(32'h1000_0010, 1'b0, 32'h0);
    tick(); tick();
    for (int k = 1; k <= 3; k++) begin
      sample();
      checks++; if (slave_PREADY !== 1'b0) begin fails++; $display("[TB] FAIL lastcycle_wait%0d: got %b expected 0", k, slave_PREADY); end
      tick();
    end
    set_slave(0, 1'b1, 1'b0, 32'h5A5A_0001);
    sample();
    checks++; if (slave_PREADY !== 1'b1 || slave_PSLVERR !== 1'b0) begin fails++; $display("[TB] FAIL lastcycle_resp: got %b/%b expected 1/0", slave_PREADY, slave_PSLVERR); end
    checks++; if (slave_PRDATA !== 32'h5A5A_0001) begin fails++; $display("[TB] FAIL lastcycle_data: got %h expected 5a5a0001", slave_PRDATA); end
    tick();
    release_req();
    set_slave(0, 1'b0, 1'b0, 32'hDEAD_0000);
  endtask

  task automatic test_slverr_min_latency();
    set_slave(4, 1'b1, 1'b1, 32'h0BAD_0004);
    tick();
    drive_req(32'h3000_4020, 1'b0, 32'h0);
    sample();
    checks++; if (slave_PREADY !== 1'b0) begin fails++; $display("[TB] FAIL minlat_c1: got %b expected 0", slave_PREADY); end
    tick(); sample();
    checks++; if (slave_PREADY !== 1'b0) begin fails++; $display("[TB] FAIL minlat_c2: got %b expected 0", slave_PREADY); end
    tick(); sample();
    checks++; if (slave_PREADY !== 1'b1 || slave_PSLVERR !== 1'b1) begin fails++; $display("[TB] FAIL minlat_resp: got %b/%b expected 1/1", slave_PREADY, slave_PSLVERR); end
    checks++; if (slave_PRDATA !== 32'h0BAD_0004) begin fails++; $display("[TB] FAIL minlat_data: got %h expected 0bad0004", slave_PRDATA); end
    tick();
    release_req();
    set_slave(4, 1'b0, 1'b0, 32'hDEAD_0004);
  endtask

  task automatic test_overlap();
    tick();
    drive_req(32'h2000_8000, 1'b1, 32'hCAFE_F00D);
    tick(); sample();
    checks++; if (master_PSEL !== 8'b0000_0010) begin fails++; $display("[TB] FAIL overlap_psel: got %b expected 00000010", master_PSEL); end
    checks++; if (master_PWRITE !== 1'b1 || master_PWDATA !== 32'hCAFE_F00D) begin fails++; $display("[TB] FAIL overlap_wdata: got %b/%h expected 1/cafef00d", master_PWRITE, master_PWDATA); end
    tick();
    set_slave(1, 1'b1, 1'b0, 32'h0);
    sample();
    checks++; if (slave_PREADY !== 1'b1 || slave_PSLVERR !== 1'b0) begin fails++; $display("[TB] FAIL overlap_resp: got %b/%b expected 1/0", slave_PREADY, slave_PSLVERR); end
    tick();
    release_req();
    set_slave(1, 1'b0, 1'b0, 32'hDEAD_0001);
  endtask

  task automatic test_boundary_and_setup_abort();
    tick();
    drive_req(32'h1A10_0FFF, 1'b0, 32'h0);
    tick(); sample();
    checks++; if (master_PSEL !== 8'b0000_0100) begin fails++; $display("[TB] FAIL bound_end_hit: got %b expected 00000100", master_PSEL); end
    release_req();
    tick(); sample();
    checks++; if (master_PSEL !== 8'h00 || master_PENABLE !== 1'b0 || slave_PREADY !== 1'b0) begin fails++; $display("[TB] FAIL setup_abort: got %b/%b/%b expected 00000000/0/0", master_PSEL, master_PENABLE, slave_PREADY); end
    tick();
    drive_req(32'h1A10_1000, 1'b0, 32'h0);
    tick(); sample();
    checks++; if (slave_PREADY !== 1'b1 || slave_PSLVERR !== 1'b1 || master_PSEL !== 8'h00) begin fails++; $display("[TB] FAIL bound_end_plus1: got %b/%b/%b expected 1/1/00000000", slave_PREADY, slave_PSLVERR, master_PSEL); end
    tick();
    release_req();
  endtask

  task automatic test_access_abort();
    tick();
    drive_req(32'h1A10_0004, 1'b0, 32'h0);
    tick(); tick(); sample();
    checks++; if (master_PENABLE !== 1'b1) begin fails++; $display("[TB] FAIL abort_in_access: got %b expected 1", master_PENABLE); end
    release_req();
    set_slave(2, 1'b1, 1'b0, 32'h1234_5678);
    #1;
    checks++; if (slave_PREADY !== 1'b0) begin fails++; $display("[TB] FAIL abort_no_resp: got %b expected 0", slave_PREADY); end
    tick(); sample();
    checks++; if (master_PSEL !== 8'h00 || master_PENABLE !== 1'b0) begin fails++; $display("[TB] FAIL abort_release: got %b/%b expected 00000000/0", master_PSEL, master_PENABLE); end
    set_slave(2, 1'b0, 1'b0, 32'hDEAD_0002);
  endtask

  task automatic test_reset_mid_transfer();
    tick();
    drive_req(32'h1A10_0004, 1'b0, 32'h0);
    tick(); tick();
    set_slave(2, 1'b1, 1'b0, 32'h1234_5678);
    sample();
    checks++; if (slave_PREADY !== 1'b1) begin fails++; $display("[TB] FAIL midrst_pre: got %b expected 1", slave_PREADY); end
    rst_n = 1'b0;
    #1;
    checks++; if (master_PSEL !== 8'h00 || master_PENABLE !== 1'b0) begin fails++; $display("[TB] FAIL midrst_master: got %b/%b expected 00000000/0", master_PSEL, master_PENABLE); end
    checks++; if (slave_PREADY !== 1'b0 || slave_PSLVERR !== 1'b0 || slave_PRDATA !== 32'h0) begin fails++; $display("[TB] FAIL midrst_resp: got %b/%b/%h expected 0/0/0", slave_PREADY, slave_PSLVERR, slave_PRDATA); end
    release_req();
    set_slave(2, 1'b0, 1'b0, 32'hDEAD_0002);
    tick();
    rst_n = 1'b1;
    tick();
    set_slave(2, 1'b1, 1'b0, 32'h0000_ABCD);
    drive_req(32'h1A10_0008, 1'b0, 32'h0);
    tick(); tick(); sample();
    checks++; if (slave_PREADY !== 1'b1 || slave_PRDATA !== 32'h0000_ABCD) begin fails++; $display("[TB] FAIL midrst_resume: got %b/%h expected 1/0000abcd", slave_PREADY, slave_PRDATA); end
    tick();
    release_req();
    set_slave(2, 1'b0, 1'b0, 32'hDEAD_0002);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    release_req();
    slave_PADDR    = '0;
    slave_PWDATA   = '0;
    slave_PWRITE   = 1'b0;
    master_PREADY  = '0;
    master_PSLVERR = '0;
    for (int i = 0; i < NB; i++) begin
      master_PRDATA[i*DW +: DW] = 32'hDEAD_0000 | i;
      start_addr[i*AW +: AW]    = 32'h3000_0000 + i * 32'h1000;
      end_addr[i*AW +: AW]      = 32'h3000_0FFF + i * 32'h1000;
    end
    start_addr[0*AW +: AW] = 32'h1000_0000; end_addr[0*AW +: AW] = 32'h1000_0FFF;
    start_addr[1*AW +: AW] = 32'h2000_0000; end_addr[1*AW +: AW] = 32'h2000_FFFF;
    start_addr[2*AW +: AW] = 32'h1A10_0000; end_addr[2*AW +: AW] = 32'h1A10_0FFF;
    start_addr[3*AW +: AW] = 32'h2000_8000; end_addr[3*AW +: AW] = 32'h2001_0FFF;

    test_reset();
    test_read();
    test_unmapped();
    test_timeout();
    test_ready_at_timeout();
    test_slverr_min_latency();
    test_overlap();
    test_boundary_and_setup_abort();
    test_access_abort();
    test_reset_mid_transfer();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/apb_node_timeout.md
APB_NODE_TIMEOUT -- requirements
Module: apb_node_timeout

Interface
REQ-001 SHALL have parameter NB_SLAVES, default 8: number of downstream APB slave ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: APB address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: APB data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, legal range 2 or more: maximum number of ACCESS cycles without slave PREADY before the node aborts the transfer.
REQ-005 SHALL be clocked by the single clock and reset by the asynchronous active-low reset: one clock; reset is asynchronous and active-low.
REQ-006 Ports, in this order:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- slave_PADDR, slave_PWDATA, slave_PWRITE, slave_PSEL, slave_PENABLE  in  ADDR_WIDTH/DATA_WIDTH/1/1/1  upstream APB request from the lint-to-APB bridge.
- slave_PRDATA, slave_PREADY, slave_PSLVERR  out  DATA_WIDTH/1/1  upstream response.
- master_PADDR, master_PWDATA, master_PWRITE  out  ADDR_WIDTH/DATA_WIDTH/1  broadcast to all slaves.
- master_PSEL  out  NB_SLAVES  one-hot slave select.
- master_PENABLE  out  1  common enable.
- master_PRDATA  in  NB_SLAVES*DATA_WIDTH  per-slave read data, flattened.
- master_PREADY, master_PSLVERR  in  NB_SLAVES  per-slave ready and error.
- START_ADDR_i, END_ADDR_i  in  NB_SLAVES*ADDR_WIDTH  inclusive address window per slave, quasi-static.

Function
REQ-007 The upstream side SHALL accept PSEL and PENABLE asserted in the same cycle, with no setup phase required.
REQ-008 FSM states SHALL be IDLE, SETUP, ACCESS and ERROR.
REQ-009 IDLE: on slave_PSEL=1, decode slave_PADDR; on a hit, register the slave index and go to SETUP; on a miss, go to ERROR.
REQ-010 Decode SHALL be a hit when START <= addr <= END; on overlapping windows the lowest index wins.
REQ-011 SETUP (one cycle): master_PSEL[idx]=1, master_PENABLE=0; then go to ACCESS.
REQ-012 ACCESS: master_PSEL[idx]=1, master_PENABLE=1; slave_PREADY, slave_PRDATA and slave_PSLVERR SHALL be driven combinationally from slave idx.
REQ-013 ACCESS: on master_PREADY[idx]=1, go to IDLE.
REQ-014 Minimum latency from upstream PSEL rise to slave_PREADY SHALL be 3 cycles, one per state IDLE, SETUP, ACCESS.
REQ-015 Timeout counter: clear on SETUP entry; increment each ACCESS cycle with PREADY=0.
REQ-016 When the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0, the node SHALL drive slave_PREADY=1, slave_PSLVERR=1, slave_PRDATA=ERR_RDATA, then go to IDLE and deassert master_PSEL.
REQ-017 PREADY arriving in the timeout cycle SHALL win: normal response, no error.
REQ-018 ERROR (one cycle): slave_PREADY=1, slave_PSLVERR=1, slave_PRDATA=ERR_RDATA; no master_PSEL asserted; then go to IDLE.
REQ-019 Outside a response cycle, slave_PREADY=0, slave_PSLVERR=0 and slave_PRDATA=0.
REQ-020 master_PADDR, master_PWDATA and master_PWRITE SHALL be pass-throughs of the upstream signals.
REQ-021 If upstream slave_PSEL drops during SETUP or ACCESS, the node SHALL return to IDLE next cycle, deassert master_PSEL/PENABLE and give no upstream response.
REQ-022 In IDLE, master_PSEL=0 and master_PENABLE=0 regardless of upstream activity.
REQ-023 A new upstream request SHALL be decoded only in IDLE.
REQ-024 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and the counter SHALL never wrap.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, counter=0, slave index=0, master_PSEL=0, master_PENABLE=0, slave_PREADY=0, slave_PSLVERR=0, slave_PRDATA=0.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no response; operation resumes in IDLE after deassertion.

Structure
REQ-027 Package apb_node_pkg SHALL hold the FSM state enum and constant ERR_RDATA = 32'hBADACCE5.
REQ-028 One combinational sub-module, apb_addr_decoder, SHALL provide first-match decode, outputting hit and idx.

Verification
REQ-029 Read with addr 0x1A10_0004 in slave 2 window [0x1A10_0000, 0x1A10_0FFF], slave PREADY after 2 ACCESS cycles, PRDATA 0x1234_5678 -> master_PSEL=8'b0000_0100; upstream PREADY on cycle 5 with PRDATA 0x1234_5678 and PSLVERR=0.
REQ-030 Access to unmapped addr 0xFFFF_0000 -> no master_PSEL; upstream PREADY=1, PSLVERR=1, PRDATA=0xBADACCE5 on cycle 2.
REQ-031 TIMEOUT_CYCLES=4, slave never ready -> PSLVERR=1 on the 4th ACCESS cycle; master_PSEL=0 next cycle.
REQ-032 TIMEOUT_CYCLES=4, slave PREADY on the 4th ACCESS cycle -> normal response with PSLVERR=0.
REQ-033 Overlapping windows for slaves 1 and 3 with write 0xCAFE_F00D -> only master_PSEL[1] asserted; PWRITE=1 and PWDATA broadcast.
REQ-034 rst_n pulsed low during ACCESS -> all outputs 0 immediately; next request completes normally.
